const_div_seq: RTL and testbench
================================

# const_div_seq

Sequential divide-by-constant unit, the inverse of the shift-and-add constant multipliers (×13, ×25, ×63). It takes a 32-bit unsigned operand and a divisor select, and produces quotient and remainder by restoring shift-subtract division, one quotient bit per cycle. It sits behind the constant-multiply datapath as its inverse, and it is also the bench oracle for checking that datapath (x·D / D == x). Input and output use valid/ready handshakes.

## Interface
- WIDTH, 32: operand and quotient width.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand presented.
- in_ready  out  1  unit can accept an operand; high only in IDLE.
- x  in  WIDTH  unsigned dividend.
- sel  in  2  divisor select: 0→13, 1→25, 2→63, 3→1.
- out_valid  out  1  q/r valid; held until accepted.
- out_ready  in  1  consumer accepts the result.
- q  out  WIDTH  quotient floor(x/D).
- r  out  6  remainder x mod D, always less than D.

## Operation
- State machine IDLE → RUN → DONE → IDLE. Reset enters IDLE.
- IDLE: in_ready=1. When in_valid && in_ready at an edge:
  - capture x into the dividend shift register;
  - capture D (decoded from sel) into a 6-bit divisor register;
  - clear the 7-bit partial remainder and the bit counter;
  - go to RUN.
- RUN: each edge performs one restoring step.
  - t = {rem[5:0], dividend MSB}; if t ≥ D then rem ← t−D and shift in quotient bit 1, else rem ← t and shift in 0.
  - The dividend/quotient register shifts left by one.
  - After WIDTH steps (counter reaches WIDTH−1), go to DONE.
- DONE: out_valid=1, q and r stable. When out_ready is high at an edge, go to IDLE.
- x and sel are sampled only at acceptance. Changes during RUN or DONE are ignored.
- sel=3 (D=1) runs the full WIDTH steps and yields q=x, r=0. There is no early termination for any divisor.
- Arithmetic widths:
  - partial remainder is 7 bits, enough because D ≤ 63 means rem < 64;
  - r = rem[5:0];
  - q·D + r == x holds exactly for every x and sel.
- Reset asserted at any time, including mid-RUN or in DONE with out_valid high, aborts immediately. No partial result is emitted.

## Timing
- Reset values: out_valid=0, q=0, r=0, state IDLE, so in_ready=1 once reset is released. Counter and internal registers are 0.
- Accept at edge t0. Steps occur at edges t1..tWIDTH. out_valid rises after edge tWIDTH, so latency is WIDTH cycles from acceptance to out_valid.
- in_ready is decoded combinationally from state. It is low from the cycle after acceptance until the cycle after the result is consumed.
- Result consumed at edge tc (out_valid && out_ready): out_valid falls after tc and in_ready rises in the same cycle.
- No same-cycle accept-and-drain. Minimum spacing between acceptances is WIDTH+2 cycles when out_ready is held high.
- out_ready high while not in DONE has no effect.
- With out_ready held low, DONE persists indefinitely and q/r do not change.

## Structure
- Package const_div_pkg:
  - divisor constants DIV13=13, DIV25=25, DIV63=63, DIV1=1;
  - the sel encoding enum;
  - the state enum {IDLE, RUN, DONE};
  - a function mapping sel to the 6-bit divisor.
- Sub-module const_div_step: combinational one-bit restoring step. Inputs are the 7-bit remainder, the incoming bit and D. Outputs are the next remainder and the quotient bit. It is instantiated once in the top, which holds the FSM, counter and registers.

## Test plan
- Reset, then x=1000, sel=0 with out_ready=1 → out_valid exactly 32 cycles after acceptance; q=76, r=12.
- x=0xFFFFFFFF, sel=2 → q=68174084 (0x0410_4104), r=3. Also x=0 → q=0, r=0.
- x=624, sel=1, out_ready low for 10 cycles after out_valid → q=24, r=24 held stable throughout; in_ready stays 0; toggling x and in_valid has no effect.
- x=0xDEADBEEF, sel=3 → q=0xDEADBEEF, r=0. Then back-to-back operands with in_valid held high → acceptances spaced exactly 34 cycles apart.
- Assert rst at step 15 of a run → out_valid, q and r go to 0 asynchronously; in_ready=1 after release. A new operand then completes correctly.
- Randomized: 10k x values over all sel values, with x·D products taken from the ×13/×25/×63 multiplier → q·D+r==x and r<D for every result; products divide back to the original x with r=0.

Source files
------------

// File: rtl/const_div_pkg.sv
// rtl/const_div_pkg.sv - shared types, divisor constants and the sel decode.
package const_div_pkg;

    localparam logic [5:0] DIV13 = 6'd13;
    localparam logic [5:0] DIV25 = 6'd25;
    localparam logic [5:0] DIV63 = 6'd63;
    localparam logic [5:0] DIV1  = 6'd1;

    typedef enum logic [1:0] {
        SEL_13 = 2'd0,
        SEL_25 = 2'd1,
        SEL_63 = 2'd2,
        SEL_1  = 2'd3
    } sel_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [5:0] sel_to_div(input sel_e s);
        case (s)
            SEL_13:  return DIV13;
            SEL_25:  return DIV25;
            SEL_63:  return DIV63;
            default: return DIV1;
        endcase
    endfunction

endpackage

// File: rtl/const_div_step.sv
// rtl/const_div_step.sv - one combinational restoring-division step.
module const_div_step (
    input  logic [6:0] rem_in,
    input  logic       bit_in,
    input  logic [5:0] div,
    output logic [6:0] rem_out,
    output logic       q_bit
);

    logic [7:0] t;

    // The running remainder never exceeds 62, so the 7-bit difference cannot wrap.
    always_comb begin
        t       = {rem_in, bit_in};
        q_bit   = (t >= {2'b00, div});
        rem_out = q_bit ? (t[6:0] - {1'b0, div}) : t[6:0];
    end

endmodule

// File: rtl/const_div_seq.sv
// rtl/const_div_seq.sv - sequential divide-by-constant (13/25/63/1), one quotient bit per cycle.
module const_div_seq
    import const_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [1:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic [5:0]       r
);

    localparam int CNT_W = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   dividend_q, dividend_d;
    logic [5:0]         div_q, div_d;
    logic [6:0]         rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [6:0]         rem_next;
    logic               q_bit;
    logic               last_step;

    const_div_step u_step (
        .rem_in  (rem_q),
        .bit_in  (dividend_q[WIDTH-1]),
        .div     (div_q),
        .rem_out (rem_next),
        .q_bit   (q_bit)
    );

    assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (last_step) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Quotient bits enter at the LSB as dividend bits leave the MSB.
    always_comb begin
        dividend_d = dividend_q;
        div_d      = div_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        if (state_q == IDLE && in_valid) begin
            dividend_d = x;
            div_d      = sel_to_div(sel_e'(sel));
            rem_d      = '0;
            cnt_d      = '0;
        end else if (state_q == RUN) begin
            dividend_d = {dividend_q[WIDTH-2:0], q_bit};
            rem_d      = rem_next;
            cnt_d      = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dividend_q <= '0;
            div_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
        end else begin
            dividend_q <= dividend_d;
            div_q      <= div_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
        end
    end

    assign q = dividend_q;
    assign r = rem_q[5:0];

endmodule

// File: tb/tb_const_div_seq.sv
// tb/tb_const_div_seq.sv - directed-vector and corner-case bench for const_div_seq.
module tb_const_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x;
    logic [1:0]  sel;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] q;
    logic [5:0]  r;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_q[$];

    const_div_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .r         (r)
    );

    always #5 clk = ~clk;

    // Inputs only change 1 time unit after a rising edge, so the falling edge sees settled values.
    always @(negedge clk) begin
        cyc++;
        if (in_valid && in_ready) acc_q.push_back(cyc);
    end

    typedef struct {
        logic [31:0] x;
        logic [1:0]  sel;
        logic [31:0] eq;
        logic [5:0]  er;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dval(input logic [1:0] s);
        case (s)
            2'd0:    return 32'd13;
            2'd1:    return 32'd25;
            2'd2:    return 32'd63;
            default: return 32'd1;
        endcase
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
    endtask

    task automatic run_op(input logic [31:0] xi, input logic [1:0] si,
                          output logic [31:0] rq, output logic [5:0] rr, output int lat);
        wait_ready();
        x = xi; sel = si; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        x = ~xi; sel = ~si;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        rq = q; rr = r;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] rq;
        logic [5:0]  rr;
        logic [31:0] hq;
        logic [5:0]  hr;
        int          lat;

        vecs[0]  = '{32'd1000,     2'd0, 32'd76,        6'd12};
        vecs[1]  = '{32'hFFFFFFFF, 2'd2, 32'h04104104,  6'd3};
        vecs[2]  = '{32'd0,        2'd0, 32'd0,         6'd0};
        vecs[3]  = '{32'd624,      2'd1, 32'd24,        6'd24};
        vecs[4]  = '{32'hDEADBEEF, 2'd3, 32'hDEADBEEF,  6'd0};
        vecs[5]  = '{32'hFFFFFFFF, 2'd0, 32'd330382099, 6'd8};
        vecs[6]  = '{32'hFFFFFFFF, 2'd1, 32'd171798691, 6'd20};
        vecs[7]  = '{32'd12,       2'd0, 32'd0,         6'd12};
        vecs[8]  = '{32'd13,       2'd0, 32'd1,         6'd0};
        vecs[9]  = '{32'd62,       2'd2, 32'd0,         6'd62};
        vecs[10] = '{32'd126,      2'd2, 32'd2,         6'd0};
        vecs[11] = '{32'd0,        2'd2, 32'd0,         6'd0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x = '0; sel = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_q", q, 0);
        check("rst_r", r, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_in_ready", in_ready, 1);

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].x, vecs[i].sel, rq, rr, lat);
            check($sformatf("vec%0d_lat", i), lat, 32);
            check($sformatf("vec%0d_q", i), rq, vecs[i].eq);
            check($sformatf("vec%0d_r", i), rr, vecs[i].er);
            check($sformatf("vec%0d_drain", i), {out_valid, in_ready}, 2'b01);
        end

        // Hold DONE with out_ready low while the inputs wiggle.
        wait_ready();
        x = 32'd624; sel = 2'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("hold_lat", lat, 32);
        hq = 32'd24; hr = 6'd24;
        for (int k = 0; k < 10; k++) begin
            x = $urandom; sel = 2'($urandom); in_valid = ~in_valid;
            @(posedge clk); #1;
            check($sformatf("hold%0d", k), {out_valid, in_ready, q, r}, {1'b1, 1'b0, hq, hr});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("hold_drain", {out_valid, in_ready}, 2'b01);

        // Back-to-back with in_valid and out_ready held high.
        acc_q.delete();
        x = 32'hDEADBEEF; sel = 2'd3; in_valid = 1'b1; out_ready = 1'b1;
        lat = 0;
        while (acc_q.size() < 3 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid) check("b2b_qr", {q, r}, {32'hDEADBEEF, 6'd0});
        end
        in_valid = 1'b0;
        if (acc_q.size() < 3) begin
            check("b2b_timeout", acc_q.size(), 3);
        end else begin
            check("b2b_gap1", acc_q[1] - acc_q[0], 34);
            check("b2b_gap2", acc_q[2] - acc_q[1], 34);
        end
        lat = 0;
        while (!in_ready && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        out_ready = 1'b0;
        check("b2b_idle", in_ready, 1);

        // Abort mid-run with an asynchronous reset.
        x = 32'd1000; sel = 2'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("abort_async", {out_valid, q, r}, {1'b0, 32'd0, 6'd0});
        check("abort_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort_release", {out_valid, in_ready}, 2'b01);
        run_op(32'd777, 2'd1, rq, rr, lat);
        check("post_abort", {lat[7:0], rq, rr}, {8'd32, 32'd31, 6'd2});

        // Abort while DONE is pending.
        x = 32'd50; sel = 2'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (33) @(posedge clk);
        #1;
        check("done_pending", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("done_abort", {out_valid, q, r}, {1'b0, 32'd0, 6'd0});
        @(posedge clk); #1;
        rst = 1'b0;

        // Randomized operands against the bench's own arithmetic.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] rx;
            logic [1:0]  rs;
            rx = $urandom;
            rs = 2'($urandom_range(0, 3));
            run_op(rx, rs, rq, rr, lat);
            check($sformatf("rand%0d", i), {rq, 26'd0, rr}, {rx / dval(rs), rx % dval(rs)});
        end

        // Products from the constant multipliers must divide back exactly.
        for (int i = 0; i < 100; i++) begin
            logic [31:0] ox;
            logic [1:0]  rs;
            logic [63:0] prod;
            rs = 2'($urandom_range(0, 2));
            ox = $urandom_range(0, 32'hFFFFFFFF / dval(rs));
            prod = 64'(ox) * 64'(dval(rs));
            run_op(prod[31:0], rs, rq, rr, lat);
            check($sformatf("prod%0d", i), {rq, rr}, {ox, 6'd0});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
